// File: rtl/i2c_target_regfile.sv
// I2C target with a parametrised register file: repeated START, pointer wrap,
// NACK of out-of-range pointers, read-only bytes sourced from ro_in.
module i2c_target_regfile #(
   parameter logic [6:0]          DEV_ADDR    = 7'h20,
   parameter int                  REGCOUNT    = 32,
   parameter int                  PTR_W       = $clog2(REGCOUNT),
   parameter logic [REGCOUNT-1:0] RO_MASK     = '0,
   parameter int                  SYNC_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  SCL_in,
   input  logic                  SDA_in,
   output logic                  SDA_out,
   input  logic [8*REGCOUNT-1:0] ro_in,
   output logic [8*REGCOUNT-1:0] registers_packed,
   output logic                  wr_strobe,
   output logic [PTR_W-1:0]      wr_index,
   output logic                  busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
      S_WRITE, S_WR_ACK, S_READ, S_RD_ACK, S_IGNORE
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_q, sda_q;
   logic                   scl_s, sda_s;
   logic                   scl_rise, scl_fall, sda_rise, sda_fall;
   logic                   start_det, stop_det;

   state_t           state;
   logic [3:0]       bit_cnt;
   logic [6:0]       shreg;
   logic [6:0]       tx;
   logic [PTR_W-1:0] ptr, ptr_inc;
   logic [7:0]       rx_byte, rd_byte;
   logic [7:0]       reg_q    [REGCOUNT];
   logic [7:0]       reg_view [REGCOUNT];

   // NOTE: non-blocking assignments in every clocked block so all flops sample
   // the pre-edge values, independent of statement order.
   // The bus idles high, so the sampling flops reset to 1 to avoid a phantom START.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA_in};
         scl_q    <= scl_s;
         sda_q    <= sda_s;
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_q;
   assign scl_fall  = ~scl_s & scl_q;
   assign sda_rise  = sda_s & ~sda_q;
   assign sda_fall  = ~sda_s & sda_q;
   assign start_det = sda_fall & scl_s & scl_q;
   assign stop_det  = sda_rise & scl_s & scl_q;

   for (genvar i = 0; i < REGCOUNT; i++) begin : g_view
      assign reg_view[i]                 = RO_MASK[i] ? ro_in[8*i +: 8] : reg_q[i];
      assign registers_packed[8*i +: 8]  = reg_view[i];
   end

   assign rx_byte = {shreg, sda_s};
   assign rd_byte = reg_view[ptr];
   assign ptr_inc = (ptr == PTR_W'(REGCOUNT - 1)) ? '0 : ptr + 1'b1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         tx        <= '0;
         ptr       <= '0;
         SDA_out   <= 1'b1;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
         wr_index  <= '0;
         // NOTE: the register file is small and its reset value is visible on
         // registers_packed, so every entry is reset rather than left as RAM.
         for (int i = 0; i < REGCOUNT; i++) reg_q[i] <= '0;
      end else begin
         wr_strobe <= 1'b0;
         if (start_det) begin
            state   <= S_ADDR;
            bit_cnt <= '0;
            SDA_out <= 1'b1;
            busy    <= 1'b1;
         end else if (stop_det) begin
            state   <= S_IDLE;
            SDA_out <= 1'b1;
            busy    <= 1'b0;
         end else begin
            case (state)
               S_ADDR, S_PTR, S_WRITE: begin
                  if (scl_rise) begin
                     shreg   <= rx_byte[6:0];
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) begin
                        case (state)
                           S_ADDR: state <= (rx_byte[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_IGNORE;
                           S_PTR: begin
                              if ({1'b0, rx_byte} < 9'(REGCOUNT)) begin
                                 ptr   <= rx_byte[PTR_W-1:0];
                                 state <= S_PTR_ACK;
                              end else begin
                                 state <= S_IGNORE;
                              end
                           end
                           default: begin
                              if (!RO_MASK[ptr]) begin
                                 reg_q[ptr] <= rx_byte;
                                 wr_strobe  <= 1'b1;
                                 wr_index   <= ptr;
                              end
                              ptr   <= ptr_inc;
                              state <= S_WR_ACK;
                           end
                        endcase
                     end
                  end
               end
               // bit_cnt 8: ACK not yet driven; 9: ACK on the bus, release at next fall
               S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
                  if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        SDA_out <= 1'b0;
                        bit_cnt <= 4'd9;
                     end else begin
                        bit_cnt <= '0;
                        if (state == S_ADDR_ACK && shreg[0]) begin
                           state   <= S_READ;
                           tx      <= rd_byte[6:0];
                           SDA_out <= rd_byte[7];
                           ptr     <= ptr_inc;
                        end else begin
                           SDA_out <= 1'b1;
                           state   <= (state == S_ADDR_ACK) ? S_PTR : S_WRITE;
                        end
                     end
                  end
               end
               S_READ: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        SDA_out <= 1'b1;
                        state   <= S_RD_ACK;
                     end else begin
                        SDA_out <= tx[6];
                        tx      <= {tx[5:0], 1'b0};
                     end
                  end
               end
               S_RD_ACK: begin
                  if (scl_rise) begin
                     if (sda_s) state   <= S_IGNORE;
                     else       bit_cnt <= 4'd9;
                  end else if (scl_fall && bit_cnt == 4'd9) begin
                     bit_cnt <= '0;
                     state   <= S_READ;
                     tx      <= rd_byte[6:0];
                     SDA_out <= rd_byte[7];
                     ptr     <= ptr_inc;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: bit-banged master, transaction-level
// register model, and a per-cycle compare of SDA_out, busy and the register file.
module tb_i2c_target_regfile;

   localparam int          RC  = 32;
   localparam logic [6:0]  DEV = 7'h20;
   localparam logic [31:0] RO  = 32'h0000_0008;
   localparam int          Q   = 6;

   logic            clk, rst_n;
   logic            scl_m, sda_m, sda_bus;
   logic            SDA_out, wr_strobe, busy;
   logic [8*RC-1:0] ro_in, registers_packed;
   logic [4:0]      wr_index;

   int   n_checks = 0;
   int   n_errors = 0;
   logic cmp_en;

   logic [7:0] m_regs [RC];
   int         m_ptr;
   logic       m_busy, m_active, exp_sda;
   int         exp_q[$];
   int         got_q[$];

   assign sda_bus = sda_m & SDA_out;

   i2c_target_regfile #(
      .DEV_ADDR(DEV), .REGCOUNT(RC), .PTR_W(5), .RO_MASK(RO), .SYNC_STAGES(2)
   ) dut (
      .clock(clk), .reset(rst_n), .SCL_in(scl_m), .SDA_in(sda_bus), .SDA_out(SDA_out),
      .ro_in(ro_in), .registers_packed(registers_packed), .wr_strobe(wr_strobe),
      .wr_index(wr_index), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete within the time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [7:0] m_view(input int i);
      return RO[i] ? ro_in[8*i +: 8] : m_regs[i];
   endfunction

   function automatic logic [255:0] m_packed();
      logic [255:0] v;
      for (int i = 0; i < RC; i++) v[8*i +: 8] = m_view(i);
      return v;
   endfunction

   // Per-cycle compare once the master pins have been still long enough to settle.
   initial begin
      int   stab;
      logic last_scl, last_sda, prev_str;
      stab = 0; last_scl = 1'b1; last_sda = 1'b1; prev_str = 1'b0;
      forever begin
         @(negedge clk);
         if (scl_m !== last_scl || sda_m !== last_sda) stab = 0;
         else if (stab < 1000) stab++;
         last_scl = scl_m;
         last_sda = sda_m;
         if (rst_n && wr_strobe) begin
            got_q.push_back(int'(wr_index));
            check("strobe_width", prev_str, 1'b0);
         end
         prev_str = wr_strobe;
         if (cmp_en && stab >= 4) begin
            check("sda_out", SDA_out, exp_sda);
            check("busy", busy, m_busy);
            check("regs", registers_packed, m_packed());
         end
      end
   end

   task automatic wait_q();
      repeat (Q) @(posedge clk);
      #1;
   endtask

   task automatic bus_start();
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b0; m_busy = 1'b1; exp_sda = 1'b1; m_active = 1'b0; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b1; m_busy = 1'b0; exp_sda = 1'b1; m_active = 1'b0; wait_q();
      wait_q();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic tgt_ack, input logic next_sda,
                            input logic do_wr, input int idx, output logic got_ack);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i]; wait_q();
         scl_m = 1'b1;
         if (i == 0 && do_wr) m_regs[idx] = b;
         wait_q(); wait_q();
         scl_m = 1'b0;
         if (i == 0) exp_sda = ~tgt_ack;
         wait_q();
      end
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      got_ack = ~sda_bus; wait_q();
      scl_m = 1'b0; exp_sda = next_sda; wait_q();
   endtask

   task automatic recv_byte(input logic [7:0] exp_b, input logic m_ack, input logic next_sda,
                            output logic [7:0] got);
      got = '0;
      for (int i = 7; i >= 0; i--) begin
         wait_q();
         scl_m = 1'b1; wait_q();
         got[i] = sda_bus; wait_q();
         scl_m = 1'b0;
         exp_sda = (i > 0) ? exp_b[(i > 0) ? i - 1 : 0] : 1'b1;
      end
      wait_q();
      sda_m = ~m_ack; wait_q();
      scl_m = 1'b1; wait_q(); wait_q();
      scl_m = 1'b0; exp_sda = next_sda; wait_q();
      sda_m = 1'b1;
   endtask

   task automatic t_addr(input logic [7:0] b);
      logic match, ack;
      logic [7:0] first;
      match = (b[7:1] == DEV);
      first = m_view(m_ptr);
      send_byte(b, match, (match && b[0]) ? first[7] : 1'b1, 1'b0, 0, ack);
      check("addr_ack", ack, match);
      m_active = match;
   endtask

   task automatic t_ptr(input logic [7:0] b);
      logic ok, ack;
      ok = m_active && (int'(b) < RC);
      send_byte(b, ok, 1'b1, 1'b0, 0, ack);
      check("ptr_ack", ack, ok);
      if (ok) m_ptr = int'(b);
      else    m_active = 1'b0;
   endtask

   task automatic t_wr(input logic [7:0] b);
      logic wr, ack;
      wr = m_active && !RO[m_ptr];
      send_byte(b, m_active, 1'b1, wr, m_ptr, ack);
      check("wr_ack", ack, m_active);
      if (wr) exp_q.push_back(m_ptr);
      if (m_active) m_ptr = (m_ptr + 1) % RC;
   endtask

   task automatic t_rd(input logic m_ack, output logic [7:0] got);
      logic [7:0] exp_b, nxt;
      exp_b = m_view(m_ptr);
      m_ptr = (m_ptr + 1) % RC;
      nxt   = m_view(m_ptr);
      recv_byte(exp_b, m_ack, m_ack ? nxt[7] : 1'b1, got);
      check("rd_data", got, exp_b);
      if (!m_ack) m_active = 1'b0;
   endtask

   task automatic check_strobes();
      check("strobe_count", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check("strobe_index", got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic model_reset();
      for (int i = 0; i < RC; i++) m_regs[i] = 8'h00;
      m_ptr = 0; m_busy = 1'b0; m_active = 1'b0; exp_sda = 1'b1;
   endtask

   initial begin
      logic [7:0] got0, got1;
      rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; cmp_en = 1'b0;
      for (int i = 0; i < RC; i++) ro_in[8*i +: 8] = 8'hE0 ^ 8'(i);
      ro_in[31:24] = 8'h77;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_sda", SDA_out, 1'b1);
      check("reset_busy", busy, 1'b0);
      check("reset_strobe", wr_strobe, 1'b0);
      check("reset_index", wr_index, 5'd0);
      check("reset_regs", registers_packed, 256'h77 << 24);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      cmp_en = 1'b1;

      // Preload reg31 and reg0 through the pointer wrap.
      bus_start(); t_addr(8'h40); t_ptr(8'h1F); t_wr(8'hC3); t_wr(8'h5A); bus_stop();
      check_strobes();

      // Two writes from pointer 5.
      bus_start(); t_addr(8'h40); t_ptr(8'h05); t_wr(8'hA5); t_wr(8'h3C); bus_stop();
      check("t1_reg5", registers_packed[47:40], 8'hA5);
      check("t1_reg6", registers_packed[55:48], 8'h3C);
      check("t1_index", wr_index, 5'd6);
      check("t1_strobes", got_q.size(), 2);
      if (got_q.size() == 2) begin
         check("t1_strobe0", got_q[0], 5);
         check("t1_strobe1", got_q[1], 6);
      end
      check_strobes();

      // Out-of-range pointer is NACKed, following data ignored, pointer stays at 7.
      bus_start(); t_addr(8'h40); t_ptr(8'h40); t_wr(8'h12); bus_stop();
      bus_start(); t_addr(8'h41); t_rd(1'b0, got0); bus_stop();
      check("t4_reg7", got0, 8'h00);
      check_strobes();

      // Repeated START read across the wrap point.
      bus_start(); t_addr(8'h40); t_ptr(8'h1F);
      bus_start(); t_addr(8'h41);
      check("t2_busy", busy, 1'b1);
      t_rd(1'b1, got0); t_rd(1'b0, got1); bus_stop();
      check("t2_reg31", got0, 8'hC3);
      check("t2_reg0", got1, 8'h5A);
      check_strobes();

      // Foreign address: never acknowledged.
      bus_start(); t_addr(8'h42); t_wr(8'h99); bus_stop();
      check_strobes();

      // Read-only register 3.
      bus_start(); t_addr(8'h40); t_ptr(8'h03); t_wr(8'h11); bus_stop();
      bus_start(); t_addr(8'h40); t_ptr(8'h03);
      bus_start(); t_addr(8'h41); t_rd(1'b0, got0); bus_stop();
      check("t5_ro_read", got0, 8'h77);
      check("t5_no_strobe", got_q.size(), 0);
      check_strobes();

      // Reset while the target holds the address ACK low.
      bus_start();
      begin
         logic [7:0] a;
         a = 8'h40;
         for (int i = 7; i >= 0; i--) begin
            sda_m = a[i]; wait_q();
            scl_m = 1'b1; wait_q(); wait_q();
            scl_m = 1'b0;
            if (i == 0) exp_sda = 1'b0;
            wait_q();
         end
      end
      sda_m = 1'b1; wait_q();
      check("t6_ack_low", SDA_out, 1'b0);
      cmp_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("t6_sda_async", SDA_out, 1'b1);
      check("t6_busy", busy, 1'b0);
      check("t6_regs", registers_packed, 256'h77 << 24);
      scl_m = 1'b1; sda_m = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      got_q.delete();
      cmp_en = 1'b1;

      // Pointer back at 0 with a cleared register file.
      bus_start(); t_addr(8'h41); t_rd(1'b0, got0); bus_stop();
      check("t6_reg0_after", got0, 8'h00);
      check_strobes();

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
